// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcode and funct
// values, ALU operation codes, mux select encodings, the sequencer state
// and the decoded instruction class.
package mips_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_NOOP    = 6'b000000;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SLT     = 6'b101010;

  // ALU operation codes driven on ALUOp
  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_SLT = 6'b101010;
  localparam logic [5:0] ALU_NOP = 6'b101100;

  // PC source mux
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  // Register file destination mux
  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  // ALU B operand mux
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOOP    = 4'd0,
    CLS_LW      = 4'd1,
    CLS_SW      = 4'd2,
    CLS_RTYPE   = 4'd3,
    CLS_ADDI    = 4'd4,
    CLS_XORI    = 4'd5,
    CLS_BNE     = 4'd6,
    CLS_J       = 4'd7,
    CLS_JAL     = 4'd8,
    CLS_JR      = 4'd9,
    CLS_SYSCALL = 4'd10,
    CLS_ILLEGAL = 4'd11
  } instr_class_e;

  // State that follows DECODE for a given instruction class
  function automatic state_e class_next_state(input instr_class_e cls);
    case (cls)
      CLS_LW, CLS_SW:          return S_MEM_ADDR;
      CLS_RTYPE:               return S_EXEC_R;
      CLS_ADDI, CLS_XORI:      return S_EXEC_I;
      CLS_BNE:                 return S_BRANCH;
      CLS_J, CLS_JAL, CLS_JR:  return S_JUMP;
      CLS_SYSCALL:             return S_HALT;
      default:                 return S_FETCH;
    endcase
  endfunction

  // ALU operation for an arithmetic R-type funct
  function automatic logic [5:0] alu_op_for_funct(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_SLT:  return ALU_SLT;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational instruction classifier: maps opcode/funct to the class the
// sequencer branches on, and flags encodings the datapath does not support.
module control_decode
  import mips_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output instr_class_e cls_o,
  output logic         illegal_o
);

  // Classify the instruction; anything unrecognised falls through as illegal
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    cls_o = CLS_ILLEGAL;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_NOOP:                cls_o = CLS_NOOP;
          FN_ADD, FN_SUB, FN_SLT: cls_o = CLS_RTYPE;
          FN_JR:                  cls_o = CLS_JR;
          FN_SYSCALL:             cls_o = CLS_SYSCALL;
          default:                cls_o = CLS_ILLEGAL;
        endcase
      end
      OP_LW:   cls_o = CLS_LW;
      OP_SW:   cls_o = CLS_SW;
      OP_ADDI: cls_o = CLS_ADDI;
      OP_XORI: cls_o = CLS_XORI;
      OP_BNE:  cls_o = CLS_BNE;
      OP_J:    cls_o = CLS_J;
      OP_JAL:  cls_o = CLS_JAL;
      default: cls_o = CLS_ILLEGAL;
    endcase
  end

  assign illegal_o = (cls_o == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the MIPS datapath. Walks each instruction through
// fetch, decode, execute, memory and writeback, stalling on mem_ready, and
// counts retired instructions.
module multicycle_control
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCEn,
  output logic [1:0]  PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [5:0]  ALUOp,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic        MemtoReg,
  output logic        WriDataSel,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  state_e       state_q, state_d;
  instr_class_e cls_q, cls_d;
  logic [5:0]   rop_q, rop_d;
  logic [31:0]  retired_q, retired_d;
  logic         illegal_q, illegal_d;
  logic         retire;

  instr_class_e dec_cls;
  logic         dec_illegal;

  control_decode u_decode (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .cls_o     (dec_cls),
    .illegal_o (dec_illegal)
  );

  // State register plus the values captured in DECODE and the retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= CLS_NOOP;
      rop_q     <= ALU_NOP;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values of the previous cycle, independent of statement order.
      state_q   <= state_d;
      cls_q     <= cls_d;
      rop_q     <= rop_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic, DECODE-time capture and retire detection
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = class_next_state(dec_cls);
        retire  = (dec_cls == CLS_NOOP);
      end
      S_MEM_ADDR: state_d = (cls_q == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R,
      S_EXEC_I:   state_d = S_ALU_WB;
      S_MEM_WB,
      S_ALU_WB,
      S_BRANCH,
      S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Class, R-type ALU op, illegal pulse and retire count for the next cycle
  always_comb begin
    cls_d     = cls_q;
    rop_d     = rop_q;
    illegal_d = 1'b0;
    if (state_q == S_DECODE) begin
      cls_d     = dec_cls;
      rop_d     = alu_op_for_funct(funct);
      illegal_d = dec_illegal;
    end
    retired_d = retired_q + (retire ? 32'd1 : 32'd0);
  end

  // Datapath control per state; PCEn in BRANCH and the FETCH enables are
  // the only terms that look at inputs directly
  always_comb begin
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCEn       = 1'b0;
    PCSource   = PC_SRC_ALU;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RT;
    ALUOp      = ALU_NOP;
    RegWrite   = 1'b0;
    RegDst     = REG_DST_RT;
    MemtoReg   = 1'b0;
    WriDataSel = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        ALUOp    = ALU_ADD;
        PCSource = PC_SRC_ALU;
        // Reset holds the state in FETCH; the write enables must not follow
        // mem_ready while it is asserted.
        IRWrite  = mem_ready & ~reset;
        PCEn     = mem_ready & ~reset;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        ALUOp   = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        RegDst     = REG_DST_RT;
        MemtoReg   = 1'b1;
        WriDataSel = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_RT;
        ALUOp   = rop_q;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = (cls_q == CLS_XORI) ? ALU_XOR : ALU_ADD;
      end
      S_ALU_WB: begin
        RegWrite   = 1'b1;
        WriDataSel = 1'b1;
        RegDst     = (cls_q == CLS_RTYPE) ? REG_DST_RD : REG_DST_RT;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_RT;
        ALUOp    = ALU_SUB;
        PCSource = PC_SRC_ALUOUT;
        PCEn     = ~zero;
      end
      S_JUMP: begin
        PCEn     = 1'b1;
        PCSource = (cls_q == CLS_JR) ? PC_SRC_RS : PC_SRC_JUMP;
        if (cls_q == CLS_JAL) begin
          RegWrite = 1'b1;
          RegDst   = REG_DST_RA;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
